// File: rtl/i2c_slave_target.sv
// i2c_slave_target: 7-bit-address I2C target that streams write bytes out and read bytes in.
// Build option: define I2C_SLAVE_GLITCH_FILTER_EN to add a 3-sample level filter on SCL/SDA.
module i2c_slave_target #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       wb_clk_i,
  input  logic       arst_i,
  input  logic       scl_pad_i,
  input  logic       sda_pad_i,
  output logic       sda_pad_o,
  output logic       sda_padoen_o,
  output logic       scl_padoen_o,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       start_o,
  output logic       stop_o,
  output logic       busy,
  output logic       rw_o
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, RD_WAIT
  } state_t;

  logic [1:0] pad_in;
  logic [1:0] line_s;   // [0] = SCL, [1] = SDA, as seen by the FSM
  assign pad_in = {sda_pad_i, scl_pad_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      logic [1:0] sync_reg;
      always_ff @(posedge wb_clk_i or posedge arst_i) begin
        if (arst_i) sync_reg <= 2'b11;
        else        sync_reg <= {sync_reg[0], pad_in[gi]};
      end
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
      // A level is accepted only once three consecutive synced samples agree.
      logic [2:0] hist_reg;
      logic       filt_reg;
      always_ff @(posedge wb_clk_i or posedge arst_i) begin
        if (arst_i) begin
          hist_reg <= 3'b111;
          filt_reg <= 1'b1;
        end else begin
          hist_reg <= {hist_reg[1:0], sync_reg[1]};
          if (hist_reg == 3'b000)      filt_reg <= 1'b0;
          else if (hist_reg == 3'b111) filt_reg <= 1'b1;
        end
      end
      assign line_s[gi] = filt_reg;
`else
      assign line_s[gi] = sync_reg[1];
`endif
    end
  endgenerate

  logic scl_s, sda_s, scl_d_reg, sda_d_reg;
  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_s = line_s[0];
  assign sda_s = line_s[1];

  always_ff @(posedge wb_clk_i or posedge arst_i) begin
    if (arst_i) begin
      scl_d_reg <= 1'b1;
      sda_d_reg <= 1'b1;
    end else begin
      scl_d_reg <= scl_s;
      sda_d_reg <= sda_s;
    end
  end

  assign scl_rise  = scl_s & ~scl_d_reg;
  assign scl_fall  = ~scl_s & scl_d_reg;
  assign start_det = scl_s & scl_d_reg & sda_d_reg & ~sda_s;
  assign stop_det  = scl_s & scl_d_reg & ~sda_d_reg & sda_s;

  state_t     state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] rx_data_reg, rx_data_next;
  logic       oen_reg, oen_next;
  logic       phase_reg, phase_next;   // second half of an ACK slot
  logic       ack_reg, ack_next;
  logic       rx_valid_reg, rx_valid_next;
  logic       tx_load_reg, tx_load_next;
  logic       start_reg, start_next;
  logic       stop_reg, stop_next;
  logic       busy_reg, busy_next;
  logic       rw_reg, rw_next;
  logic [7:0] shift_in;

  assign shift_in = {shift_reg[6:0], sda_s};

  always_ff @(posedge wb_clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_reg    <= IDLE;
      cnt_reg      <= 3'd0;
      shift_reg    <= 8'h00;
      rx_data_reg  <= 8'h00;
      oen_reg      <= 1'b1;
      phase_reg    <= 1'b0;
      ack_reg      <= 1'b0;
      rx_valid_reg <= 1'b0;
      tx_load_reg  <= 1'b0;
      start_reg    <= 1'b0;
      stop_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      rw_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      shift_reg    <= shift_next;
      rx_data_reg  <= rx_data_next;
      oen_reg      <= oen_next;
      phase_reg    <= phase_next;
      ack_reg      <= ack_next;
      rx_valid_reg <= rx_valid_next;
      tx_load_reg  <= tx_load_next;
      start_reg    <= start_next;
      stop_reg     <= stop_next;
      busy_reg     <= busy_next;
      rw_reg       <= rw_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    shift_next    = shift_reg;
    rx_data_next  = rx_data_reg;
    oen_next      = oen_reg;
    phase_next    = phase_reg;
    ack_next      = ack_reg;
    busy_next     = busy_reg;
    rw_next       = rw_reg;
    rx_valid_next = 1'b0;
    tx_load_next  = 1'b0;
    start_next    = 1'b0;
    stop_next     = 1'b0;

    // Bus conditions override whatever bit-level event happens in the same cycle.
    if (start_det) begin
      state_next = ADDR;
      cnt_next   = 3'd0;
      oen_next   = 1'b1;
      phase_next = 1'b0;
      busy_next  = 1'b0;
      start_next = 1'b1;
    end else if (stop_det) begin
      state_next = IDLE;
      oen_next   = 1'b1;
      phase_next = 1'b0;
      busy_next  = 1'b0;
      stop_next  = 1'b1;
    end else begin
      case (state_reg)
        ADDR: begin
          if (scl_rise) begin
            shift_next = shift_in;
            cnt_next   = cnt_reg + 3'd1;
            if (cnt_reg == 3'd7) begin
              if (shift_reg[6:0] == SLAVE_ADDR) begin
                rw_next    = sda_s;
                busy_next  = 1'b1;
                phase_next = 1'b0;
                state_next = ADDR_ACK;
              end else begin
                oen_next   = 1'b1;
                state_next = IDLE;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!phase_reg) begin
              oen_next   = 1'b0;
              phase_next = 1'b1;
            end else begin
              phase_next = 1'b0;
              cnt_next   = 3'd0;
              if (rw_reg) begin
                shift_next   = {tx_data[6:0], 1'b1};
                oen_next     = tx_data[7];
                tx_load_next = 1'b1;
                state_next   = RD_DATA;
              end else begin
                oen_next   = 1'b1;
                state_next = WR_DATA;
              end
            end
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            shift_next = shift_in;
            cnt_next   = cnt_reg + 3'd1;
            if (cnt_reg == 3'd7) begin
              ack_next   = rx_ready;
              phase_next = 1'b0;
              state_next = WR_ACK;
              if (rx_ready) begin
                rx_data_next  = shift_in;
                rx_valid_next = 1'b1;
              end
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            if (!phase_reg) begin
              oen_next   = ~ack_reg;
              phase_next = 1'b1;
            end else begin
              oen_next   = 1'b1;
              phase_next = 1'b0;
              state_next = WR_DATA;
            end
          end
        end
        RD_DATA: begin
          if (scl_rise) begin
            cnt_next = cnt_reg + 3'd1;
          end else if (scl_fall) begin
            // The counter has wrapped only after the master clocked all 8 bits.
            if (cnt_reg == 3'd0) begin
              oen_next   = 1'b1;
              phase_next = 1'b0;
              state_next = RD_ACK;
            end else begin
              oen_next   = shift_reg[7];
              shift_next = {shift_reg[6:0], 1'b1};
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_s) state_next = RD_WAIT;
            else       phase_next = 1'b1;
          end else if (scl_fall && phase_reg) begin
            phase_next   = 1'b0;
            cnt_next     = 3'd0;
            shift_next   = {tx_data[6:0], 1'b1};
            oen_next     = tx_data[7];
            tx_load_next = 1'b1;
            state_next   = RD_DATA;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sda_pad_o    = 1'b0;
  assign scl_padoen_o = 1'b1;
  assign sda_padoen_o = oen_reg;
  assign rx_data      = rx_data_reg;
  assign rx_valid     = rx_valid_reg;
  assign tx_load      = tx_load_reg;
  assign start_o      = start_reg;
  assign stop_o       = stop_reg;
  assign busy         = busy_reg;
  assign rw_o         = rw_reg;

endmodule
